regfile_watch: RTL and testbench

- Parametrised, synthesizable debug tap that replaces the hard-coded $monitor of three fixed registers in processor benches.
- Snoops the register-file write-back port of the multicycle core and watches NUM_CH runtime-programmable architectural registers.
- Each qualifying write is queued as an event {channel, reg index, data, timestamp} in an internal FIFO.
- Events drain through a valid/ready port to a bench, UART or trace sink.

---
 rtl/regfile_watch_if.sv | 46 ++++
 rtl/regfile_watch.sv | 176 +++++++++++++++++
 tb/tb_regfile_watch.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_watch_if.sv
// Bundle of the regfile_watch configuration, write-back snoop and event-drain signals.
// master = the side that configures the tap, feeds write-backs and drains events.
// slave  = the regfile_watch tap itself.
interface regfile_watch_if #(
    parameter int DATA_W = 64,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 8,
    parameter int TS_W   = 32
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [4:0]        cfg_idx;
    logic              cfg_en;
    logic              wb_we;
    logic [4:0]        wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              ev_valid;
    logic              ev_ready;
    logic [CH_W-1:0]   ev_ch;
    logic [4:0]        ev_idx;
    logic [DATA_W-1:0] ev_data;
    logic [TS_W-1:0]   ev_stamp;
    logic [CNT_W-1:0]  ev_count;
    logic              overflow;
    logic [15:0]       drop_cnt;
    logic              clr_ovf;

    modport master (
        output cfg_we, cfg_ch, cfg_idx, cfg_en,
        output wb_we, wb_addr, wb_data,
        output ev_ready, clr_ovf,
        input  ev_valid, ev_ch, ev_idx, ev_data, ev_stamp, ev_count,
        input  overflow, drop_cnt
    );

    modport slave (
        input  cfg_we, cfg_ch, cfg_idx, cfg_en,
        input  wb_we, wb_addr, wb_data,
        input  ev_ready, clr_ovf,
        output ev_valid, ev_ch, ev_idx, ev_data, ev_stamp, ev_count,
        output overflow, drop_cnt
    );
endinterface

// File: rtl/regfile_watch.sv
// regfile_watch: snoops the register-file write-back port, watches NUM_CH
// programmable architectural registers and queues qualifying writes as
// {channel, index, data, timestamp} events in a first-word-fall-through FIFO.
// Optional macro REGWATCH_TSTAMP_EN builds the timestamp counter and storage;
// without it ev_stamp is tied to zero.
module regfile_watch #(
    parameter int DATA_W      = 64,
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 8,
    parameter int TS_W        = 32,
    parameter int CHANGE_ONLY = 1
) (
    input  logic           clk,
    input  logic           reset_n,
    regfile_watch_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Channel configuration and shadow state
    logic [4:0]        r_chIdx  [NUM_CH];
    logic [DATA_W-1:0] r_shadow [NUM_CH];
    logic [NUM_CH-1:0] r_chEn;
    logic [NUM_CH-1:0] r_primed;

    // Event storage, addressed by the low pointer bits
    logic [CH_W-1:0]   r_memCh   [DEPTH];
    logic [4:0]        r_memIdx  [DEPTH];
    logic [DATA_W-1:0] r_memData [DEPTH];

    logic [PTR_W:0]    r_wrPtr;
    logic [PTR_W:0]    r_rdPtr;
    logic              r_overflow;
    logic [15:0]       r_dropCnt;

    logic [NUM_CH-1:0] w_match;
    logic [NUM_CH-1:0] w_qual;
    logic              w_push;
    logic [CH_W-1:0]   w_pushCh;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_wrEn;
    logic              w_drop;
    logic [PTR_W-1:0]  w_wrAddr;
    logic [PTR_W-1:0]  w_rdAddr;

    // Match each channel against the write-back and pick the lowest qualifying one to push
    always_comb begin
        w_match  = '0;
        w_qual   = '0;
        w_push   = 1'b0;
        w_pushCh = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_match[c] = r_chEn[c] && bus.wb_we && (bus.wb_addr == r_chIdx[c]) && (bus.wb_addr != 5'd0);
            w_qual[c]  = w_match[c] && ((CHANGE_ONLY == 0) || !r_primed[c] || (bus.wb_data != r_shadow[c]));
        end
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (w_qual[c]) begin
                w_push   = 1'b1;
                w_pushCh = CH_W'(c);
            end
        end
    end

    // Shadow/primed update on every match; a config write replaces idx/en and unprimes the channel
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_chEn   <= '0;
            r_primed <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_chIdx[c]  <= 5'd0;
                r_shadow[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_match[c]) begin
                    r_shadow[c] <= bus.wb_data;
                    r_primed[c] <= 1'b1;
                end
                if (bus.cfg_we && (bus.cfg_ch == CH_W'(c))) begin
                    r_chIdx[c]  <= bus.cfg_idx;
                    r_chEn[c]   <= bus.cfg_en;
                    r_primed[c] <= 1'b0;
                end
            end
        end
    end

    assign w_count  = r_wrPtr - r_rdPtr;
    assign w_empty  = (w_count == '0);
    assign w_full   = (w_count == CNT_W'(DEPTH));
    assign w_pop    = !w_empty && bus.ev_ready;
    assign w_wrEn   = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;
    assign w_wrAddr = r_wrPtr[PTR_W-1:0];
    assign w_rdAddr = r_rdPtr[PTR_W-1:0];

    // Event payload storage; contents are only visible while the FIFO is non-empty
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_memCh[w_wrAddr]   <= w_pushCh;
            r_memIdx[w_wrAddr]  <= bus.wb_addr;
            r_memData[w_wrAddr] <= bus.wb_data;
        end
    end

    // Read/write pointers with an extra wrap bit so full and empty are distinguishable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
        end else begin
            if (w_wrEn) begin
                r_wrPtr <= r_wrPtr + {{PTR_W{1'b0}}, 1'b1};
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + {{PTR_W{1'b0}}, 1'b1};
            end
        end
    end

    // Sticky overflow and saturating drop counter; a drop in the clear cycle wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= 16'd0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (bus.clr_ovf) begin
                r_dropCnt <= 16'd1;
            end else if (r_dropCnt != 16'hFFFF) begin
                r_dropCnt <= r_dropCnt + 16'd1;
            end
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
            r_dropCnt  <= 16'd0;
        end
    end

`ifdef REGWATCH_TSTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_memStamp [DEPTH];

    // Free-running timestamp, wraps naturally at 2^TS_W
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + {{(TS_W-1){1'b0}}, 1'b1};
        end
    end

    // Stamp captured alongside the payload, using the counter value of the sampling cycle
    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            r_memStamp[w_wrAddr] <= r_ts;
        end
    end

    assign bus.ev_stamp = w_empty ? {TS_W{1'b0}} : r_memStamp[w_rdAddr];
`else
    assign bus.ev_stamp = {TS_W{1'b0}};
`endif

    assign bus.ev_valid = !w_empty;
    assign bus.ev_ch    = w_empty ? '0 : r_memCh[w_rdAddr];
    assign bus.ev_idx   = w_empty ? 5'd0 : r_memIdx[w_rdAddr];
    assign bus.ev_data  = w_empty ? '0 : r_memData[w_rdAddr];
    assign bus.ev_count = w_count;
    assign bus.overflow = r_overflow;
    assign bus.drop_cnt = r_dropCnt;

endmodule

// File: tb/tb_regfile_watch.sv
// Self-checking bench for regfile_watch: a directed vector table for the basic
// match/qualify/pop behaviour plus hand-written overflow, wrap and reset sequences.
// A second instance with CHANGE_ONLY=0 shares all inputs.
module tb_regfile_watch;
    localparam int DATA_W = 64;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 8;
    localparam int TS_W   = 32;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    regfile_watch_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .TS_W(TS_W)) ifc0 ();
    regfile_watch_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .TS_W(TS_W)) ifc1 ();

    regfile_watch #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .TS_W(TS_W), .CHANGE_ONLY(1)) u_dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc0)
    );

    regfile_watch #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .TS_W(TS_W), .CHANGE_ONLY(0)) u_dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifc1)
    );

    assign ifc1.cfg_we   = ifc0.cfg_we;
    assign ifc1.cfg_ch   = ifc0.cfg_ch;
    assign ifc1.cfg_idx  = ifc0.cfg_idx;
    assign ifc1.cfg_en   = ifc0.cfg_en;
    assign ifc1.wb_we    = ifc0.wb_we;
    assign ifc1.wb_addr  = ifc0.wb_addr;
    assign ifc1.wb_data  = ifc0.wb_data;
    assign ifc1.ev_ready = ifc0.ev_ready;
    assign ifc1.clr_ovf  = ifc0.clr_ovf;

    // 10 ns clock
    always #5 clk = ~clk;

    // Reference cycle counter mirroring the expected timestamp value
    int tbCycle;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) tbCycle <= 0;
        else          tbCycle <= tbCycle + 1;
    end

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [4:0]  addr;
        logic [63:0] data;
        logic        ready;
        logic        expValid;
        logic [1:0]  expCh;
        logic [4:0]  expIdx;
        logic [63:0] expData;
        int          expCount;
        int          expCount1;
        int          stampRef;
    } vec_t;

    vec_t vecs [10];
    int   stampAt [10];
    int   q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic we, input logic [4:0] addr, input logic [63:0] data, input logic ready);
        ifc0.wb_we    = we;
        ifc0.wb_addr  = addr;
        ifc0.wb_data  = data;
        ifc0.ev_ready = ready;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cfgWrite(input logic [1:0] ch, input logic [4:0] idx, input logic en);
        ifc0.cfg_we  = 1'b1;
        ifc0.cfg_ch  = ch;
        ifc0.cfg_idx = idx;
        ifc0.cfg_en  = en;
        tick();
        ifc0.cfg_we  = 1'b0;
    endtask

    // Drives the whole sequence and prints the summary
    initial begin
        logic [63:0] expStamp;

        ifc0.cfg_we   = 1'b0;
        ifc0.cfg_ch   = '0;
        ifc0.cfg_idx  = '0;
        ifc0.cfg_en   = 1'b0;
        ifc0.clr_ovf  = 1'b0;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);

        vecs[0] = '{1'b1, 5'd10, 64'd5, 1'b0, 1'b1, 2'd0, 5'd10, 64'd5, 1, 1, 0};
        vecs[1] = '{1'b1, 5'd21, 64'd7, 1'b0, 1'b1, 2'd0, 5'd10, 64'd5, 2, 2, 0};
        vecs[2] = '{1'b1, 5'd21, 64'd7, 1'b0, 1'b1, 2'd0, 5'd10, 64'd5, 2, 3, 0};
        vecs[3] = '{1'b1, 5'd21, 64'd9, 1'b0, 1'b1, 2'd0, 5'd10, 64'd5, 3, 4, 0};
        vecs[4] = '{1'b1, 5'd0,  64'd1, 1'b0, 1'b1, 2'd0, 5'd10, 64'd5, 3, 4, 0};
        vecs[5] = '{1'b1, 5'd22, 64'd3, 1'b0, 1'b1, 2'd0, 5'd10, 64'd5, 3, 4, 0};
        vecs[6] = '{1'b0, 5'd0,  64'd0, 1'b1, 1'b1, 2'd1, 5'd21, 64'd7, 2, 3, 1};
        vecs[7] = '{1'b0, 5'd0,  64'd0, 1'b1, 1'b1, 2'd1, 5'd21, 64'd9, 1, 2, 3};
        vecs[8] = '{1'b0, 5'd0,  64'd0, 1'b1, 1'b0, 2'd0, 5'd0,  64'd0, 0, 1, -1};
        vecs[9] = '{1'b0, 5'd0,  64'd0, 1'b1, 1'b0, 2'd0, 5'd0,  64'd0, 0, 0, -1};

        // Reset state
        repeat (3) tick();
        checkOutput("reset ev_valid", 64'(ifc0.ev_valid), 64'd0);
        checkOutput("reset ev_count", 64'(ifc0.ev_count), 64'd0);
        checkOutput("reset overflow", 64'(ifc0.overflow), 64'd0);
        checkOutput("reset drop_cnt", 64'(ifc0.drop_cnt), 64'd0);
        checkOutput("reset ev_data", ifc0.ev_data, 64'd0);
        checkOutput("reset ev_stamp", 64'(ifc0.ev_stamp), 64'd0);
        reset_n = 1'b1;

        cfgWrite(2'd0, 5'd10, 1'b1);
        cfgWrite(2'd1, 5'd21, 1'b1);
        cfgWrite(2'd2, 5'd21, 1'b1);
        checkOutput("cfg ev_count", 64'(ifc0.ev_count), 64'd0);

        // Table-driven basic behaviour
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].ready);
            stampAt[i] = tbCycle;
            tick();
            checkOutput($sformatf("vec%0d ev_valid", i), 64'(ifc0.ev_valid), 64'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d ev_ch", i), 64'(ifc0.ev_ch), 64'(vecs[i].expCh));
            checkOutput($sformatf("vec%0d ev_idx", i), 64'(ifc0.ev_idx), 64'(vecs[i].expIdx));
            checkOutput($sformatf("vec%0d ev_data", i), ifc0.ev_data, vecs[i].expData);
            checkOutput($sformatf("vec%0d ev_count", i), 64'(ifc0.ev_count), 64'(vecs[i].expCount));
            checkOutput($sformatf("vec%0d all-writes ev_count", i), 64'(ifc1.ev_count), 64'(vecs[i].expCount1));
`ifdef REGWATCH_TSTAMP_EN
            expStamp = (vecs[i].stampRef >= 0) ? 64'(stampAt[vecs[i].stampRef]) : 64'd0;
`else
            expStamp = 64'd0;
`endif
            checkOutput($sformatf("vec%0d ev_stamp", i), 64'(ifc0.ev_stamp), expStamp);
        end

        // Overflow: ten distinct writes into an 8-deep FIFO with no pop
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1, 5'd10, 64'(100 + k), 1'b0);
            tick();
            if (q.size() < DEPTH) q.push_back(100 + k);
        end
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("full ev_count", 64'(ifc0.ev_count), 64'(DEPTH));
        checkOutput("full overflow", 64'(ifc0.overflow), 64'd1);
        checkOutput("full drop_cnt", 64'(ifc0.drop_cnt), 64'd2);
        checkOutput("full head data", ifc0.ev_data, 64'(q[0]));

        // Clear and drop in the same cycle: the drop wins
        ifc0.clr_ovf = 1'b1;
        applyStimulus(1'b1, 5'd10, 64'd120, 1'b0);
        tick();
        ifc0.clr_ovf = 1'b0;
        checkOutput("clr+drop overflow", 64'(ifc0.overflow), 64'd1);
        checkOutput("clr+drop drop_cnt", 64'(ifc0.drop_cnt), 64'd1);

        // Single pop while full
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b1);
        tick();
        void'(q.pop_front());
        checkOutput("pop head data", ifc0.ev_data, 64'(q[0]));
        checkOutput("pop ev_count", 64'(ifc0.ev_count), 64'(DEPTH - 1));

        // Plain clear
        ifc0.clr_ovf = 1'b1;
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        tick();
        ifc0.clr_ovf = 1'b0;
        checkOutput("clr overflow", 64'(ifc0.overflow), 64'd0);
        checkOutput("clr drop_cnt", 64'(ifc0.drop_cnt), 64'd0);

        // Refill, then push and pop together while full across a pointer wrap
        applyStimulus(1'b1, 5'd10, 64'd110, 1'b0);
        tick();
        q.push_back(110);
        checkOutput("refill ev_count", 64'(ifc0.ev_count), 64'(DEPTH));
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 5'd10, 64'(200 + k), 1'b1);
            tick();
            void'(q.pop_front());
            q.push_back(200 + k);
            checkOutput($sformatf("wrap%0d ev_count", k), 64'(ifc0.ev_count), 64'(DEPTH));
            checkOutput($sformatf("wrap%0d head data", k), ifc0.ev_data, 64'(q[0]));
        end
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("wrap overflow", 64'(ifc0.overflow), 64'd0);
        checkOutput("wrap drop_cnt", 64'(ifc0.drop_cnt), 64'd0);

        // Drain in order
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b0, 5'd0, 64'd0, 1'b1);
            tick();
            void'(q.pop_front());
            if (q.size() > 0) checkOutput($sformatf("drain%0d head data", k), ifc0.ev_data, 64'(q[0]));
        end
        checkOutput("drained ev_count", 64'(ifc0.ev_count), 64'd0);
        checkOutput("drained ev_valid", 64'(ifc0.ev_valid), 64'd0);

        // Reset mid-stream with three events queued
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 5'd21, 64'(30 + k), 1'b0);
            tick();
        end
        checkOutput("prereset ev_count", 64'(ifc0.ev_count), 64'd3);
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        reset_n = 1'b0;
        #1;
        checkOutput("midreset ev_valid", 64'(ifc0.ev_valid), 64'd0);
        checkOutput("midreset ev_count", 64'(ifc0.ev_count), 64'd0);
        checkOutput("midreset overflow", 64'(ifc0.overflow), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Channels are disabled after reset, so watched registers log nothing
        applyStimulus(1'b1, 5'd21, 64'd33, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd10, 64'd5, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("postreset ev_count", 64'(ifc0.ev_count), 64'd0);

        // Reconfigured channel is unprimed: a write equal to the zero shadow still logs
        cfgWrite(2'd0, 5'd10, 1'b1);
        applyStimulus(1'b1, 5'd10, 64'd0, 1'b0);
        tick();
        checkOutput("unprimed ev_count", 64'(ifc0.ev_count), 64'd1);
        checkOutput("unprimed ev_data", ifc0.ev_data, 64'd0);
        checkOutput("unprimed ev_idx", 64'(ifc0.ev_idx), 64'd10);
        applyStimulus(1'b1, 5'd10, 64'd0, 1'b0);
        tick();
        checkOutput("primed same ev_count", 64'(ifc0.ev_count), 64'd1);

        // Config and write in the same cycle: old config matches, new one unprimes
        ifc0.cfg_we  = 1'b1;
        ifc0.cfg_ch  = 2'd0;
        ifc0.cfg_idx = 5'd10;
        ifc0.cfg_en  = 1'b1;
        applyStimulus(1'b1, 5'd10, 64'd0, 1'b0);
        tick();
        ifc0.cfg_we  = 1'b0;
        checkOutput("cfg+wb ev_count", 64'(ifc0.ev_count), 64'd1);
        applyStimulus(1'b1, 5'd10, 64'd0, 1'b0);
        tick();
        checkOutput("reprimed ev_count", 64'(ifc0.ev_count), 64'd2);

        // Disable in the same cycle as a write: that write still logs, the next does not
        ifc0.cfg_we  = 1'b1;
        ifc0.cfg_ch  = 2'd0;
        ifc0.cfg_idx = 5'd10;
        ifc0.cfg_en  = 1'b0;
        applyStimulus(1'b1, 5'd10, 64'd7, 1'b0);
        tick();
        ifc0.cfg_we  = 1'b0;
        checkOutput("disable+wb ev_count", 64'(ifc0.ev_count), 64'd3);
        applyStimulus(1'b1, 5'd10, 64'd8, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd0, 64'd0, 1'b0);
        checkOutput("disabled ev_count", 64'(ifc0.ev_count), 64'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
